// File: rtl/clk_div8_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div8_if
// Description : Output bundle of the clk_div8 divider: divided clock and,
//               with CLKDIV8_STROBE_EN, a one-cycle strobe on its rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div8_if;
  logic clk6;
`ifdef CLKDIV8_STROBE_EN
  logic div_stb;

  modport master (output clk6, output div_stb);
  modport slave  (input  clk6, input  div_stb);
`else
  modport master (output clk6);
  modport slave  (input  clk6);
`endif
endinterface : clk_div8_if
`default_nettype wire

// File: rtl/clk_div8.sv
`default_nettype none
// ============================================================================
// Module      : clk_div8
// Description : Synchronous 50%-duty clock divider (1/DIV), flop-driven output.
//               Optional macro CLKDIV8_STROBE_EN adds div_stb, a one-cycle
//               pulse coincident with each rising edge of clk6.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div8 #(
  parameter int DIV = 8
) (
  input  wire logic   clk,
  input  wire logic   rst_,
  clk_div8_if.master  div_if
);

  localparam int HALF_W = ((DIV / 2) > 1) ? $clog2(DIV / 2) : 1;
  localparam logic [HALF_W-1:0] C_HALF_MAX = HALF_W'(DIV / 2 - 1);
  localparam logic [HALF_W-1:0] C_ONE      = HALF_W'(1);

  generate
    if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
      $fatal(1, "clk_div8: DIV must be even and >= 2");
    end
  endgenerate

  logic [HALF_W-1:0] hcnt_q, hcnt_d;
  logic              clk6_q, clk6_d;
  logic              wrap;

  assign wrap = (hcnt_q == C_HALF_MAX);

  always_comb begin
    hcnt_d = hcnt_q + C_ONE;
    clk6_d = clk6_q;
    if (wrap) begin
      hcnt_d = '0;
      clk6_d = ~clk6_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      hcnt_q <= '0;
      clk6_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      clk6_q <= clk6_d;
    end
  end

  assign div_if.clk6 = clk6_q;

`ifdef CLKDIV8_STROBE_EN
  logic stb_q, stb_d;

  // Fires on the same edge that clk6 goes 0->1.
  assign stb_d = wrap && !clk6_q;

  always_ff @(posedge clk) begin
    if (rst_) begin
      stb_q <= 1'b0;
    end else begin
      stb_q <= stb_d;
    end
  end

  assign div_if.div_stb = stb_q;
`endif

endmodule : clk_div8
`default_nettype wire

// File: tb/tb_clk_div8.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div8
// Description : Self-checking bench for clk_div8 (DIV = 2, 4, 6, 8, 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div8;

  localparam int NV = 6;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;

  always #5 clk = ~clk;

  clk_div8_if if8 ();
  clk_div8_if if2 ();
  clk_div8_if if4 ();
  clk_div8_if if6 ();
  clk_div8_if if16 ();

  clk_div8 #(.DIV(8))  u_dut8  (.clk(clk), .rst_(rst_), .div_if(if8));
  clk_div8 #(.DIV(2))  u_dut2  (.clk(clk), .rst_(rst_), .div_if(if2));
  clk_div8 #(.DIV(4))  u_dut4  (.clk(clk), .rst_(rst_), .div_if(if4));
  clk_div8 #(.DIV(6))  u_dut6  (.clk(clk), .rst_(rst_), .div_if(if6));
  clk_div8 #(.DIV(16)) u_dut16 (.clk(clk), .rst_(rst_), .div_if(if16));

  // bit0 DIV8, bit1 DIV2, bit2 DIV4, bit3 DIV6, bit4 DIV16, bit5 strobe
  logic [NV-1:0] obs;
  assign obs[0] = if8.clk6;
  assign obs[1] = if2.clk6;
  assign obs[2] = if4.clk6;
  assign obs[3] = if6.clk6;
  assign obs[4] = if16.clk6;
`ifdef CLKDIV8_STROBE_EN
  assign obs[5] = if8.div_stb;
`else
  assign obs[5] = 1'b0;
`endif

  logic [NV-1:0] sb_q[$];
  int checks   = 0;
  int failures = 0;
  int n_edge   = 0;

  // n = rising edges since reset release (0 while in reset).
  function automatic logic exp_clk(int n, int d);
    if (n == 0) return 1'b0;
    return ((n / (d / 2)) % 2) == 1;
  endfunction

  function automatic logic [NV-1:0] model(int n);
    logic [NV-1:0] v;
    v[0] = exp_clk(n, 8);
    v[1] = exp_clk(n, 2);
    v[2] = exp_clk(n, 4);
    v[3] = exp_clk(n, 6);
    v[4] = exp_clk(n, 16);
`ifdef CLKDIV8_STROBE_EN
    v[5] = (n > 0) && ((n % 4) == 0) && (((n / 4) % 2) == 1);
`else
    v[5] = 1'b0;
`endif
    return v;
  endfunction

  task automatic advance();
    @(posedge clk);
    n_edge = rst_ ? 0 : n_edge + 1;
    sb_q.push_back(model(n_edge));
    #1;
  endtask

  task automatic set_rst(input logic v);
    @(negedge clk);
    rst_ = v;
  endtask

  task automatic test_reset();
    logic [NV-1:0] e;
    set_rst(1'b1);
    for (int i = 0; i < 3; i++) begin
      advance();
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_hold_%0d obs=%b exp=%b", i, obs, e);
      end
      checks++;
      if (obs[0] !== 1'b0) begin
        failures++;
        $display("FAIL reset_clk6_%0d obs=%b exp=0", i, obs[0]);
      end
    end
  endtask

  task automatic test_basic();
    logic [NV-1:0] e;
    logic prev;
    int last_rise, last_fall, rises;
    last_rise = -1; last_fall = -1; rises = 0;
    prev = 1'b0;
    set_rst(1'b0);
    for (int i = 0; i < 44; i++) begin
      advance();
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL basic_cycle%0d obs=%b exp=%b", n_edge, obs, e);
      end
      if (!prev && obs[0] === 1'b1) begin
        rises++;
        checks++;
        if (last_fall < 0) begin
          if (n_edge != 4) begin
            failures++;
            $display("FAIL basic_first_rise edge=%0d exp=4", n_edge);
          end
        end else if (n_edge - last_fall != 4) begin
          failures++;
          $display("FAIL basic_low_len got=%0d exp=4", n_edge - last_fall);
        end
        last_rise = n_edge;
      end else if (prev && obs[0] === 1'b0) begin
        checks++;
        if (n_edge - last_rise != 4) begin
          failures++;
          $display("FAIL basic_high_len got=%0d exp=4", n_edge - last_rise);
        end
        last_fall = n_edge;
      end
      prev = obs[0];
    end
    checks++;
    if (rises != 6) begin
      failures++;
      $display("FAIL basic_rise_count got=%0d exp=6", rises);
    end
  endtask

  task automatic test_reset_mid_high();
    logic [NV-1:0] e;
    int rise_at;
    set_rst(1'b1);
    advance(); void'(sb_q.pop_front());
    set_rst(1'b0);
    for (int i = 0; i < 6; i++) begin
      advance();
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mid_high_pre%0d obs=%b exp=%b", i, obs, e);
      end
    end
    set_rst(1'b1);
    advance();
    e = sb_q.pop_front();
    checks++;
    if (obs[0] !== 1'b0 || obs !== e) begin
      failures++;
      $display("FAIL mid_high_reset obs=%b exp=%b", obs, e);
    end
    set_rst(1'b0);
    rise_at = -1;
    for (int i = 1; i <= 16 && rise_at < 0; i++) begin
      advance();
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mid_high_post%0d obs=%b exp=%b", i, obs, e);
      end
      if (obs[0] === 1'b1) rise_at = i;
    end
    checks++;
    if (rise_at != 4) begin
      failures++;
      $display("FAIL mid_high_rise_edge got=%0d exp=4", rise_at);
    end
  endtask

  task automatic test_reset_mid_low();
    logic [NV-1:0] e;
    set_rst(1'b1);
    advance(); void'(sb_q.pop_front());
    set_rst(1'b0);
    for (int i = 0; i < 3; i++) begin
      advance(); void'(sb_q.pop_front());
    end
    set_rst(1'b1);
    advance();
    e = sb_q.pop_front();
    checks++;
    if (obs[0] !== 1'b0 || obs !== e) begin
      failures++;
      $display("FAIL mid_low_reset obs=%b exp=%b", obs, e);
    end
    set_rst(1'b0);
    for (int i = 1; i <= 16; i++) begin
      advance();
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mid_low_post%0d obs=%b exp=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_sweep();
    logic [NV-1:0] e;
    logic prev2;
    set_rst(1'b1);
    advance(); void'(sb_q.pop_front());
    set_rst(1'b0);
    prev2 = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      advance();
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL sweep_cycle%0d obs=%b exp=%b", i, obs, e);
      end
      checks++;
      if (obs[1] !== ~prev2) begin
        failures++;
        $display("FAIL sweep_div2_toggle%0d obs=%b exp=%b", i, obs[1], ~prev2);
      end
      prev2 = obs[1];
    end
  endtask

`ifdef CLKDIV8_STROBE_EN
  task automatic test_strobe();
    logic [NV-1:0] e;
    int pulses;
    set_rst(1'b1);
    for (int i = 0; i < 3; i++) begin
      advance(); void'(sb_q.pop_front());
      checks++;
      if (obs[5] !== 1'b0) begin
        failures++;
        $display("FAIL strobe_in_reset%0d obs=%b exp=0", i, obs[5]);
      end
    end
    set_rst(1'b0);
    pulses = 0;
    for (int i = 1; i <= 64; i++) begin
      advance();
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL strobe_cycle%0d obs=%b exp=%b", i, obs, e);
      end
      if (obs[5] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 8) begin
      failures++;
      $display("FAIL strobe_count got=%0d exp=8", pulses);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_high();
    test_reset_mid_low();
    test_sweep();
`ifdef CLKDIV8_STROBE_EN
    test_strobe();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_clk_div8
`default_nettype wire
